// File: rtl/serial_sub_if.sv
// Handshake/data bundle for serial_sub: start/a/b in, busy/done/diff/borrow out.
// Carries ovf only when SERIAL_SUB_OVF_EN is defined; dbg_state mirrors the FSM.
interface serial_sub_if #(
  parameter int WIDTH = 8
) ();
  // start is sampled only while the block is idle (busy=0, done=0); a/b are
  // captured on that same edge. done is a one-cycle pulse and diff/borrow stay
  // valid from the done cycle until the next accepted start.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [1:0]       dbg_state;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, ovf, dbg_state
  );
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, ovf, dbg_state
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, dbg_state
  );
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, dbg_state
  );
`endif
endinterface

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: LSB-first, one bit per cycle, WIDTH+1 cycle latency.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_sub_if.slave bus
);

  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic x_bit, y_bit, d_bit, bout_bit;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    work_d   = work_q;
    diff_d   = diff_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    x_bit    = a_sh_q[0];
    y_bit    = b_sh_q[0];
    d_bit    = x_bit ^ y_bit ^ bin_q;
    bout_bit = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & bin_q);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          work_d  = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        work_d = {d_bit, work_q[WIDTH-1:1]};
        bin_d  = bout_bit;
        cnt_d  = cnt_q + CW'(1);
        // Visible outputs change only here, so they hold the old result during RUN.
        if (cnt_q == LAST_BIT) begin
          diff_d   = {d_bit, work_q[WIDTH-1:1]};
          borrow_d = bout_bit;
`ifdef SERIAL_SUB_OVF_EN
          // On the last bit x/y are the operand MSBs and d is the result MSB.
          ovf_d    = (x_bit ^ y_bit) & (d_bit ^ x_bit);
`endif
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      work_q   <= '0;
      diff_q   <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      work_q   <= work_d;
      diff_q   <= diff_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.dbg_state = state_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule
